// File: rtl/cam_pkg.sv
// Shared types and helpers for the camera FIFO readout arbiter.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package cam_pkg;

  localparam int NCAM   = 4;
  localparam int CW     = 2;
  localparam int DATA_W = 32;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_BURST = 1'b1
  } state_t;

  // Result of a rotating-priority search.
  typedef struct packed {
    logic          found;
    logic [CW-1:0] idx;
  } pick_t;

  // One buffered output word with its source camera.
  typedef struct packed {
    logic [CW-1:0]     cam;
    logic [DATA_W-1:0] data;
  } word_t;

  // First set bit of req at or after ptr, wrapping modulo NCAM.
  // Walks the offsets backwards so the smallest offset is written last and wins.
  function automatic pick_t rr_pick(input logic [NCAM-1:0] req, input logic [CW-1:0] ptr);
    pick_t         res;
    logic [CW-1:0] j;
    res = '0;
    for (int i = NCAM - 1; i >= 0; i--) begin
      j = ptr + CW'(i);
      if (req[j]) begin
        res.found = 1'b1;
        res.idx   = j;
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/cam_skid_buf.sv
// 2-entry FIFO-ordered buffer for {camera tag, word} returning from the FIFO read port.
// Latency: 0 cycles when empty (push flows straight to the output), else FIFO order.
// Backpressure: holds words while out_ready is low; caller must never push into a full buffer.
module cam_skid_buf
  import cam_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              push,
  input  logic [CW-1:0]     push_cam,
  input  logic [DATA_W-1:0] push_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CW-1:0]     out_cam,
  output logic [1:0]        occ
);

  word_t      ent0;
  word_t      ent1;
  word_t      in_word;
  word_t      head;
  logic [1:0] cnt;
  logic [1:0] cnt_after_pop;
  logic       mem_pop;
  logic       store;

  // Head selection, flow-through when empty, and push/pop bookkeeping.
  always_comb begin
    in_word       = '{cam: push_cam, data: push_data};
    mem_pop       = (cnt != 2'd0) && out_ready;
    store         = push && !((cnt == 2'd0) && out_ready);
    cnt_after_pop = cnt - {1'b0, mem_pop};
    out_valid     = (cnt != 2'd0) || push;
    head          = '0;
    if (cnt != 2'd0) begin
      head = ent0;
    end else if (push) begin
      head = in_word;
    end
    out_data = head.data;
    out_cam  = head.cam;
    occ      = cnt;
  end

  // Storage: shift on pop, then write the incoming word behind the remaining entries.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt  <= 2'd0;
      ent0 <= '0;
      ent1 <= '0;
    end else begin
      if (mem_pop) begin
        ent0 <= ent1;
      end
      if (store) begin
        if (cnt_after_pop == 2'd0) begin
          ent0 <= in_word;
        end else begin
          ent1 <= in_word;
        end
      end
      cnt <= cnt_after_pop + {1'b0, store};
    end
  end

endmodule

// File: rtl/cam_fifo_arbiter.sv
// Bursts words out of four camera FIFOs onto one tagged valid/ready stream, almost-full first, else round-robin.
// Latency: FIFO non-empty in IDLE at t -> cam_rden at t+1 -> out_valid at t+2; 1 idle cycle between bursts.
// Backpressure: reads stop whenever buffered plus in-flight words would exceed two; nothing is dropped.
module cam_fifo_arbiter
  import cam_pkg::*;
#(
  parameter int BURST_LEN = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   enable,
  input  logic [NCAM-1:0]        cam_empty,
  input  logic [NCAM-1:0]        cam_afull,
  output logic [NCAM-1:0]        cam_rden,
  input  logic [NCAM*DATA_W-1:0] cam_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [DATA_W-1:0]      out_data,
  output logic [CW-1:0]          out_cam,
  output logic                   busy,
  output logic                   tp_state
);

  localparam logic [7:0] BURST_MAX = 8'(BURST_LEN);

  state_t            state;
  state_t            state_nxt;
  logic [CW-1:0]     grant;
  logic [CW-1:0]     rr_ptr;
  logic [7:0]        count;
  logic              inflight;
  logic [CW-1:0]     tag;
  logic [1:0]        occ;
  logic              rd_en;
  logic              pop;
  logic              slot_ok;
  logic              under_limit;
  logic              last_word;
  logic [NCAM-1:0]   nonempty;
  pick_t             pick_af;
  pick_t             pick_ne;
  pick_t             pick;
  logic [DATA_W-1:0] cam_words [NCAM];

  // Candidate selection: almost-full and non-empty cameras beat plain non-empty ones.
  always_comb begin
    nonempty    = ~cam_empty;
    pick_af     = rr_pick(cam_afull & nonempty, rr_ptr);
    pick_ne     = rr_pick(nonempty, rr_ptr);
    pick        = pick_af.found ? pick_af : pick_ne;
    pop         = out_valid && out_ready;
    slot_ok     = ({1'b0, occ} + {2'b0, inflight}) < (3'd2 + {2'b0, pop});
    under_limit = count < BURST_MAX;
    last_word   = count == (BURST_MAX - 8'd1);
    for (int i = 0; i < NCAM; i++) begin
      cam_words[i] = cam_data[i*DATA_W +: DATA_W];
    end
  end

  // Next state and read strobe.
  always_comb begin
    state_nxt = state;
    rd_en     = 1'b0;
    cam_rden  = '0;
    case (state)
      ST_IDLE: begin
        if (enable && pick_ne.found) begin
          state_nxt = ST_BURST;
        end
      end
      ST_BURST: begin
        rd_en = !reset && !cam_empty[grant] && under_limit && slot_ok;
        if (rd_en) begin
          cam_rden[grant] = 1'b1;
        end
        if (!under_limit || (rd_en && last_word) || (cam_empty[grant] && !rd_en)) begin
          state_nxt = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Grant, pointer, burst count and in-flight read tracking.
  always_ff @(posedge clk) begin
    if (reset) begin
      grant    <= '0;
      rr_ptr   <= '0;
      count    <= 8'd0;
      inflight <= 1'b0;
      tag      <= '0;
    end else begin
      if (state == ST_IDLE && state_nxt == ST_BURST) begin
        grant  <= pick.idx;
        rr_ptr <= pick.idx + CW'(1);
        count  <= 8'd0;
      end else if (rd_en) begin
        count <= count + 8'd1;
      end
      inflight <= rd_en;
      if (rd_en) begin
        tag <= grant;
      end
    end
  end

  cam_skid_buf u_skid (
    .clk       (clk),
    .reset     (reset),
    .push      (inflight),
    .push_cam  (tag),
    .push_data (cam_words[tag]),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_cam   (out_cam),
    .occ       (occ)
  );

  assign busy     = (state == ST_BURST) || inflight || (occ != 2'd0);
  assign tp_state = (state == ST_BURST);

endmodule

// File: tb/tb_cam_fifo_arbiter.sv
module tb_cam_fifo_arbiter;
  import cam_pkg::*;

  logic                   clk = 1'b0;
  logic                   reset;
  logic                   enable;
  logic [NCAM-1:0]        cam_empty;
  logic [NCAM-1:0]        cam_afull;
  logic [NCAM-1:0]        cam_rden;
  logic [NCAM*DATA_W-1:0] cam_data;
  logic                   out_valid;
  logic                   out_ready;
  logic [DATA_W-1:0]      out_data;
  logic [CW-1:0]          out_cam;
  logic                   busy;
  logic                   tp_state;

  int checks   = 0;
  int failures = 0;

  cam_fifo_arbiter #(.BURST_LEN(16)) dut (
    .clk(clk), .reset(reset), .enable(enable), .cam_empty(cam_empty), .cam_afull(cam_afull),
    .cam_rden(cam_rden), .cam_data(cam_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_cam(out_cam), .busy(busy), .tp_state(tp_state)
  );

  always #5 clk = ~clk;

  // Camera FIFO model: registered read data and registered empty flag.
  logic [31:0] mem [4][64];
  int          wp [4] = '{0, 0, 0, 0};
  int          rp [4] = '{0, 0, 0, 0};
  int          seq [4] = '{0, 0, 0, 0};
  logic [31:0] cam_q [4] = '{32'd0, 32'd0, 32'd0, 32'd0};
  int          underflow = 0;

  always @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (cam_rden[i]) begin
        if (wp[i] != rp[i]) begin
          cam_q[i] <= mem[i][rp[i] % 64];
          rp[i]    <= rp[i] + 1;
        end else begin
          underflow <= underflow + 1;
        end
      end
    end
  end

  always_comb begin
    for (int i = 0; i < 4; i++) begin
      cam_empty[i]          = (wp[i] == rp[i]);
      cam_data[i*32 +: 32]  = cam_q[i];
    end
  end

  function automatic logic [31:0] wval(input int c, input int n);
    return 32'hCA000000 + 32'(c << 16) + 32'(n);
  endfunction

  // Output / read-strobe logger, sampled mid-cycle.
  logic [31:0] out_dat_log [256];
  int          out_cam_log [256];
  int          out_cyc_log [256];
  int          rd_log [256];
  int          n_out = 0;
  int          n_rd = 0;
  int          max_outst = 0;
  int          cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (out_valid && out_ready && n_out < 256) begin
      out_dat_log[n_out] = out_data;
      out_cam_log[n_out] = int'(out_cam);
      out_cyc_log[n_out] = cyc;
      n_out++;
    end
    if (cam_rden != 4'b0000 && n_rd < 256) begin
      case (cam_rden)
        4'b0001: rd_log[n_rd] = 0;
        4'b0010: rd_log[n_rd] = 1;
        4'b0100: rd_log[n_rd] = 2;
        4'b1000: rd_log[n_rd] = 3;
        default: rd_log[n_rd] = 7;
      endcase
      n_rd++;
    end
    if (n_rd - n_out > max_outst) max_outst = n_rd - n_out;
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic load(input int c, input int n);
    for (int k = 0; k < n; k++) begin
      mem[c][wp[c] % 64] = wval(c, seq[c]);
      wp[c]  = wp[c] + 1;
      seq[c] = seq[c] + 1;
    end
  endtask

  task automatic flush;
    for (int c = 0; c < 4; c++) begin
      wp[c]  = rp[c];
      seq[c] = 0;
    end
  endtask

  task automatic clr_logs;
    n_out = 0;
    n_rd = 0;
    max_outst = 0;
  endtask

  // Leaves the bench at +1 ns into the first cycle with reset low.
  task automatic apply_reset;
    reset = 1'b1; enable = 1'b1; out_ready = 1'b1; cam_afull = 4'b0000;
    flush;
    repeat (3) tick;
    reset = 1'b0;
    clr_logs;
  endtask

  task automatic test_reset;
    reset = 1'b1; enable = 1'b1; out_ready = 1'b1; cam_afull = 4'b0000;
    flush;
    for (int c = 0; c < 4; c++) load(c, 4);
    for (int k = 0; k < 3; k++) begin
      tick; #1;
      checks++;
      if (cam_rden !== 4'b0000 || out_valid !== 1'b0 || busy !== 1'b0 || tp_state !== 1'b0) begin
        failures++;
        $display("FAIL reset_hold k=%0d rden=%b ov=%b busy=%b tp=%b exp all zero", k, cam_rden, out_valid, busy, tp_state);
      end
    end
    checks++;
    if (out_data !== 32'd0 || out_cam !== 2'd0) begin
      failures++;
      $display("FAIL reset_outdata data=%h cam=%0d exp 0/0", out_data, out_cam);
    end
    reset = 1'b0;
    checks++;
    if (cam_rden !== 4'b0000) begin
      failures++;
      $display("FAIL reset_release_c0 rden=%b exp 0000", cam_rden);
    end
    tick; #1;
    checks++;
    if (cam_rden !== 4'b0001 || tp_state !== 1'b1) begin
      failures++;
      $display("FAIL reset_first_rden rden=%b tp=%b exp 0001/1", cam_rden, tp_state);
    end
  endtask

  task automatic test_early_term;
    logic [3:0] exp_rden [7] = '{4'h0, 4'h2, 4'h2, 4'h2, 4'h0, 4'h0, 4'h0};
    logic       exp_ov   [7] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    logic       exp_busy [7] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    logic       exp_tp   [7] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    apply_reset;
    load(1, 3);
    for (int c = 0; c < 7; c++) begin
      #1;
      checks++;
      if (cam_rden !== exp_rden[c] || out_valid !== exp_ov[c] || busy !== exp_busy[c] || tp_state !== exp_tp[c]) begin
        failures++;
        $display("FAIL early_ctrl c=%0d rden=%b ov=%b busy=%b tp=%b exp %b/%b/%b/%b",
                 c, cam_rden, out_valid, busy, tp_state, exp_rden[c], exp_ov[c], exp_busy[c], exp_tp[c]);
      end
      if (exp_ov[c]) begin
        checks++;
        if (out_data !== wval(1, c - 2) || out_cam !== 2'd1) begin
          failures++;
          $display("FAIL early_data c=%0d got=%h/%0d exp=%h/1", c, out_data, out_cam, wval(1, c - 2));
        end
      end
      tick;
    end
  endtask

  task automatic test_afull;
    int exp_c [6] = '{2, 2, 0, 0, 1, 1};
    int exp_n [6] = '{0, 1, 0, 1, 0, 1};
    apply_reset;
    cam_afull = 4'b0100;
    load(0, 2); load(1, 2); load(2, 2);
    for (int k = 0; k < 40 && n_out < 6; k++) tick;
    checks++;
    if (n_out != 6 || n_rd != 6) begin
      failures++;
      $display("FAIL afull_count outs=%0d rds=%0d exp 6/6", n_out, n_rd);
    end else begin
      for (int k = 0; k < 6; k++) begin
        checks++;
        if (rd_log[k] != exp_c[k] || out_dat_log[k] !== wval(exp_c[k], exp_n[k]) || out_cam_log[k] != exp_c[k]) begin
          failures++;
          $display("FAIL afull_order k=%0d rd=%0d data=%h cam=%0d exp rd=%0d data=%h",
                   k, rd_log[k], out_dat_log[k], out_cam_log[k], exp_c[k], wval(exp_c[k], exp_n[k]));
        end
      end
    end
    cam_afull = 4'b0000;
  endtask

  task automatic test_round_robin;
    int n [4];
    int b;
    int c;
    apply_reset;
    for (int i = 0; i < 4; i++) begin
      load(i, 40);
      n[i] = 0;
    end
    for (int k = 0; k < 400 && n_out < 160; k++) tick;
    checks++;
    if (n_out != 160 || n_rd != 160) begin
      failures++;
      $display("FAIL rr_count outs=%0d rds=%0d exp 160/160", n_out, n_rd);
    end else begin
      for (int k = 0; k < 160; k++) begin
        b = (k < 128) ? k / 16 : 8 + (k - 128) / 8;
        c = b % 4;
        checks++;
        if (rd_log[k] != c || out_dat_log[k] !== wval(c, n[c]) || out_cam_log[k] != c) begin
          failures++;
          $display("FAIL rr_order k=%0d rd=%0d data=%h cam=%0d exp cam=%0d data=%h",
                   k, rd_log[k], out_dat_log[k], out_cam_log[k], c, wval(c, n[c]));
        end
        n[c]++;
      end
      checks++;
      if (out_cyc_log[127] - out_cyc_log[0] != 134) begin
        failures++;
        $display("FAIL rr_timing span=%0d exp 134", out_cyc_log[127] - out_cyc_log[0]);
      end
    end
  endtask

  task automatic test_backpressure;
    apply_reset;
    load(0, 10);
    for (int c = 0; c < 40; c++) begin
      out_ready = !(c >= 5 && c <= 12);
      #1;
      if (c == 13) begin
        checks++;
        if (n_rd != 5 || n_out != 3) begin
          failures++;
          $display("FAIL bp_stall rds=%0d outs=%0d exp 5/3", n_rd, n_out);
        end
      end
      tick;
    end
    checks++;
    if (max_outst > 2 || underflow != 0) begin
      failures++;
      $display("FAIL bp_occupancy max=%0d underflow=%0d exp <=2/0", max_outst, underflow);
    end
    checks++;
    if (n_out != 10 || n_rd != 10) begin
      failures++;
      $display("FAIL bp_count outs=%0d rds=%0d exp 10/10", n_out, n_rd);
    end else begin
      for (int k = 0; k < 10; k++) begin
        checks++;
        if (out_dat_log[k] !== wval(0, k) || out_cam_log[k] != 0) begin
          failures++;
          $display("FAIL bp_data k=%0d got=%h exp=%h", k, out_dat_log[k], wval(0, k));
        end
      end
    end
  endtask

  task automatic test_reset_mid_burst;
    int exp_c [7] = '{0, 0, 3, 3, 3, 3, 3};
    int exp_n [7] = '{0, 1, 5, 6, 7, 8, 9};
    apply_reset;
    load(3, 10);
    for (int c = 0; c < 6; c++) begin
      out_ready = (c < 5);
      tick;
    end
    out_ready = 1'b0;
    reset = 1'b1;
    #1;
    checks++;
    if (cam_rden !== 4'b0000) begin
      failures++;
      $display("FAIL midrst_gate rden=%b exp 0000", cam_rden);
    end
    tick; #1;
    checks++;
    if (out_valid !== 1'b0 || tp_state !== 1'b0 || busy !== 1'b0 || cam_rden !== 4'b0000) begin
      failures++;
      $display("FAIL midrst_after ov=%b tp=%b busy=%b rden=%b exp 0/0/0/0000", out_valid, tp_state, busy, cam_rden);
    end
    reset = 1'b0;
    out_ready = 1'b1;
    clr_logs;
    load(0, 2);
    tick; #1;
    checks++;
    if (cam_rden !== 4'b0001) begin
      failures++;
      $display("FAIL midrst_regrant rden=%b exp 0001", cam_rden);
    end
    for (int k = 0; k < 60 && n_out < 7; k++) tick;
    checks++;
    if (n_out != 7) begin
      failures++;
      $display("FAIL midrst_count outs=%0d exp 7", n_out);
    end else begin
      for (int k = 0; k < 7; k++) begin
        checks++;
        if (out_dat_log[k] !== wval(exp_c[k], exp_n[k]) || out_cam_log[k] != exp_c[k]) begin
          failures++;
          $display("FAIL midrst_data k=%0d got=%h/%0d exp=%h/%0d",
                   k, out_dat_log[k], out_cam_log[k], wval(exp_c[k], exp_n[k]), exp_c[k]);
        end
      end
    end
  endtask

  initial begin
    test_reset;
    test_early_term;
    test_afull;
    test_round_robin;
    test_backpressure;
    test_reset_mid_burst;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
